// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver, NB data bits LSB first, CLKS_PER_BIT clocks per bit.
// Optional stop-bit checking with a BREAK state is enabled by defining UART_RX_FRAME_ERR_EN.
`default_nettype none

module uart_rx #(
    parameter int NB           = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    input  logic          i_Rx_Serial,
    output logic          o_Rx_DV,
    output logic [NB-1:0] o_Rx_Byte,
    output logic          o_Rx_Active,
    output logic          o_Rx_Frame_Err
);

    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW  = $clog2(NB);

    localparam logic [CW-1:0] CNT_BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_START   = CW'((MID > 0) ? MID - 1 : 0);
    localparam logic [BW-1:0] BIT_LAST    = BW'(NB - 1);

`ifdef UART_RX_FRAME_ERR_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_n;
    logic [CW-1:0]   clk_cnt, clk_cnt_n;
    logic [BW-1:0]   bit_cnt, bit_cnt_n;
    logic [NB-1:0]   shreg, shreg_n;
    logic [NB-1:0]   byte_n;
    logic            dv_n, active_n, ferr_n;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= IDLE;
            clk_cnt        <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            o_Rx_Byte      <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            state          <= state_n;
            clk_cnt        <= clk_cnt_n;
            bit_cnt        <= bit_cnt_n;
            shreg          <= shreg_n;
            o_Rx_Byte      <= byte_n;
            o_Rx_DV        <= dv_n;
            o_Rx_Active    <= active_n;
            o_Rx_Frame_Err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt + CW'(1);
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        byte_n    = o_Rx_Byte;
        dv_n      = 1'b0;
        ferr_n    = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                if (!i_Rx_Serial) begin
                    bit_cnt_n = '0;
                    // With MID == 0 the detecting edge is itself the start sample.
                    state_n   = (MID == 0) ? DATA : START;
                end
            end
            START: begin
                if (clk_cnt == CNT_START) begin
                    clk_cnt_n = '0;
                    state_n   = i_Rx_Serial ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_BIT_END) begin
                    clk_cnt_n = '0;
                    shreg_n   = {i_Rx_Serial, shreg[NB-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            STOP: begin
                if (clk_cnt == CNT_BIT_END) begin
                    clk_cnt_n = '0;
                    byte_n    = shreg;
                    dv_n      = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                    if (!i_Rx_Serial) begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n   = IDLE;
`endif
                end
            end
`ifdef UART_RX_FRAME_ERR_EN
            BREAK: begin
                clk_cnt_n = '0;
                if (i_Rx_Serial) begin
                    state_n = IDLE;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase

        active_n = (state_n == START) || (state_n == DATA) || (state_n == STOP);
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter NB, default 8: data bits per frame, NB >= 2.
REQ-002 Parameter CLKS_PER_BIT, default 1: clocks per serial bit, >= 1; MID = (CLKS_PER_BIT-1)/2, integer division.
REQ-003 i_Clock  input  1  sole clock; all logic on rising edge.
REQ-004 i_Reset  input  1  reset, synchronous, active-high.
REQ-005 i_Rx_Serial  input  1  serial line in the i_Clock domain; idle high; no internal synchronizer.
REQ-006 o_Rx_DV  output  1  one-cycle pulse; o_Rx_Byte holds a new word.
REQ-007 o_Rx_Byte  output  NB  last received word, bit 0 first on the line.
REQ-008 o_Rx_Active  output  1  high from start detection until the end of the frame.
REQ-009 o_Rx_Frame_Err  output  1  pulse coincident with o_Rx_DV when the stop bit sampled low.

Function
REQ-010 Frame format: start bit 0, NB data bits LSB first, stop bit 1, no parity.
REQ-011 States: IDLE, START, DATA, STOP, BREAK.
REQ-012 Edge E0 is the first edge in IDLE that samples i_Rx_Serial = 0; FSM leaves IDLE and o_Rx_Active rises at E0.
REQ-013 Frame bit k (start k=0, data k=1..NB, stop k=NB+1) is sampled at edge E0 + k*CLKS_PER_BIT + MID.
REQ-014 For CLKS_PER_BIT = 1 the E0 sample is the start sample; START is skipped and data bit 0 is sampled at E0+1.
REQ-015 START: a sample of 1 at the start sample point is a glitch; return to IDLE with no output pulse.
REQ-016 DATA: bit counter runs 0..NB-1; it wraps to 0 on entry to STOP and is never read out of range.
REQ-017 STOP: at the stop sample edge, o_Rx_Byte loads the assembled word, o_Rx_DV = 1 for exactly one cycle, and o_Rx_Active falls.
REQ-018 o_Rx_Byte holds its value until the next o_Rx_DV.
REQ-019 After a good stop bit the FSM is in IDLE on the next edge; a low sample at stop-edge+1 is a valid new E0.
REQ-020 This accepts back-to-back frames separated by one idle-high bit time.
REQ-021 Latency: o_Rx_DV is visible after edge E0 + (NB+1)*CLKS_PER_BIT + MID.
REQ-022 i_Rx_Serial is ignored except at sample points and in IDLE and BREAK.

Reset
REQ-023 i_Reset high at any edge forces IDLE.
REQ-024 i_Reset high clears the bit counter, the clock counter and the shift register.
REQ-025 Reset values: o_Rx_DV = 0, o_Rx_Byte = 0, o_Rx_Active = 0, o_Rx_Frame_Err = 0.
REQ-026 Reset mid-frame discards the partial word with no o_Rx_DV.
REQ-027 Reset takes priority over a simultaneous start detection.

Configuration
REQ-028 Macro UART_RX_FRAME_ERR_EN.
REQ-029 Defined: a stop sample of 0 still pulses o_Rx_DV with the received word and pulses o_Rx_Frame_Err in the same cycle.
REQ-030 Defined: after a bad stop bit the FSM enters BREAK and stays there until i_Rx_Serial samples 1, then goes to IDLE.
REQ-031 Not defined: the stop bit is not checked, o_Rx_Frame_Err is tied 0, BREAK is absent, and STOP always returns to IDLE.

Verification
REQ-032 NB=8, CLKS_PER_BIT=1; line 1,0,1,0,1,0,0,1,0,1,1 from cycle 0 (start at cycle 1) -> o_Rx_DV high exactly one cycle after edge 10, o_Rx_Byte = 0xA5, o_Rx_Frame_Err = 0.
REQ-033 Two frames 0x3C then 0xFF with one idle-high cycle between -> two o_Rx_DV pulses 11 cycles apart, bytes 0x3C then 0xFF.
REQ-034 CLKS_PER_BIT=4; line low 1 cycle then high -> no o_Rx_DV, FSM back in IDLE by the E0+1 edge.
REQ-035 CLKS_PER_BIT=4; valid 0x81 -> o_Rx_DV after edge E0+37, o_Rx_Byte = 0x81.
REQ-036 UART_RX_FRAME_ERR_EN defined; 0x55 with stop bit 0, line held low 5 more cycles -> o_Rx_DV and o_Rx_Frame_Err pulse together, no new frame until the line returns high.
REQ-037 i_Reset pulsed at data bit 4 of 0xF0 -> all outputs 0, no o_Rx_DV; the next full 0x12 frame is received correctly.
